wait_time_calc: RTL and testbench
=================================

Name: wait_time_calc

Overview:
- Parametrised, sequential successor to the combinational wait-time lookup in the bank-queue (SBqM) controller.
- Computes the estimated customer wait time as Wtime = SVC_TIME * (Pcount + Tcount - 1) / Tcount, using floor division. The result is 0 when Pcount = 0 or Tcount = 0.
- Replaces the fixed 32-entry table with a handshaked multi-cycle divider, so queue depth, teller count and per-customer service time can scale.
- Sits between the people/teller counters and the display driver.

Parameters:
- P_W, 3, width of Pcount (queue depth up to 2^P_W-1).
- T_W, 2, width of Tcount (tellers up to 2^T_W-1).
- SVC_TIME, 3, service time per customer in display units; must be ≥ 1.
- W_W, 5, width of Wtime.
- NUM_W, derived localparam, bit width of SVC_TIME*((2^P_W-1)+(2^T_W-1)-1). With defaults, max numerator = 27, so NUM_W = 5.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, request carries a valid Pcount/Tcount.
- in_ready, out, 1, block can accept a request.
- Pcount, in, P_W, number of people in queue.
- Tcount, in, T_W, number of active tellers.
- out_valid, out, 1, Wtime/overflow hold a completed result.
- out_ready, in, 1, consumer accepts the result.
- Wtime, out, W_W, wait time, saturated to W_W bits.
- overflow, out, 1, true quotient exceeded 2^W_W-1.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state = IDLE; in_ready = 1; out_valid = 0; Wtime = 0; overflow = 0; busy = 0; divider registers = 0. An in-flight request is discarded with no output.
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid (accept cycle C0), latch numerator N = SVC_TIME*(Pcount+Tcount-1) at NUM_W bits and divisor D = Tcount.
  - If Pcount = 0 or Tcount = 0: quotient = 0, go directly to DONE, out_valid from C0+1.
  - Otherwise go to DIV with bit counter = NUM_W.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first, for exactly NUM_W cycles.
  - Remainder width is T_W+1.
  - Then go to DONE. out_valid is high from C0+NUM_W+1 (cycle 6 with defaults).
- DONE:
  - out_valid = 1.
  - Wtime = quotient if quotient ≤ 2^W_W-1, else all ones with overflow = 1.
  - Wtime/overflow are registered on DONE entry and stay stable while out_ready = 0.
  - When out_valid & out_ready: go to IDLE and clear out_valid the next cycle.
- in_ready is 1 only in IDLE. There is no request overlap; in_valid outside IDLE is ignored.
- Wtime and overflow keep their last value after out_valid falls, until the next DONE entry.
- Pcount and Tcount are sampled only in the accept cycle; later changes have no effect.
- Result with defaults is bit-identical to the legacy table for all 32 (Tcount, Pcount) combinations.

Decomposition:
- Package sbqm_pkg:
  - FSM state enum (IDLE/DIV/DONE).
  - Function computing NUM_W from P_W, T_W, SVC_TIME.
  - Default parameter constants.
- Sub-module seq_divider (parametrised numerator/divisor widths, start/done pulses).
- wait_time_calc holds the FSM, the numerator build, the special-case bypass and the saturation.

Test Plan:
- Sweep all 32 (Tcount, Pcount) pairs at defaults, out_ready = 1. Expected: e.g. T=1,P=7 → Wtime = 21; T=2,P=2 → 4; T=3,P=3 → 5; T=2,P=7 → 12.
- Latency: T=1,P=1 accepted at C0 → out_valid first high at C0+6, Wtime = 3, in_ready low C0+1..C0+6.
- Zero bypass: T=0,P=5 → out_valid at C0+1, Wtime = 0. Also T=3,P=0 → 0 in 1 cycle.
- Backpressure: hold out_ready = 0 for 4 cycles in DONE → Wtime, overflow and out_valid stable, in_ready = 0, in_valid ignored. Release → IDLE next cycle.
- Overflow: SVC_TIME = 5, W_W = 4, T=1, P=7 → true quotient 35, Wtime = 15, overflow = 1.
- Reset mid-DIV: assert rst 2 cycles after accept → outputs immediately at reset values, no out_valid. After release, a new request T=2,P=4 → 7.

Source files
------------

// File: rtl/sbqm_pkg.sv
// Shared types and constants for the bank-queue (SBqM) wait-time path.
package sbqm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned P_W_DEF      = 3;
  localparam int unsigned T_W_DEF      = 2;
  localparam int unsigned SVC_TIME_DEF = 3;
  localparam int unsigned W_W_DEF      = 5;

  // Bits needed to hold the largest numerator svc*((2^p_w-1)+(2^t_w-1)-1).
  function automatic int unsigned num_width(input int unsigned p_w,
                                            input int unsigned t_w,
                                            input int unsigned svc);
    int unsigned max_num;
    int unsigned w;
    max_num = svc * (((32'd1 << p_w) - 32'd1) + ((32'd1 << t_w) - 32'd1) - 32'd1);
    w = 1;
    while ((max_num >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first, N_W cycles per
// division. The quotient register doubles as the numerator shift register.
// done_o is high during the final iteration and quot_o then carries the
// finished quotient, so the caller can register it on the same edge.
module seq_divider
  import sbqm_pkg::*;
#(
  parameter int unsigned N_W = 5,
  parameter int unsigned D_W = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [N_W-1:0] num_i,
  input  logic [D_W-1:0] den_i,
  output logic           done_o,
  output logic [N_W-1:0] quot_o
);

  localparam int unsigned C_W = $clog2(N_W + 1);

  logic [D_W:0]   rem_q, rem_d;
  logic [D_W:0]   trial;
  logic [N_W-1:0] quo_q, quo_d;
  logic [D_W-1:0] den_q;
  logic [C_W-1:0] cnt_q;
  logic           run_q;
  logic           q_bit;

  // One restoring step: shift in next numerator bit, subtract if it fits.
  always_comb begin
    trial  = (rem_q << 1) | (D_W+1)'(quo_q[N_W-1]);
    q_bit  = (trial >= (D_W+1)'(den_q));
    rem_d  = q_bit ? (trial - (D_W+1)'(den_q)) : trial;
    quo_d  = (quo_q << 1) | N_W'(q_bit);
    done_o = run_q && (cnt_q == C_W'(1));
    quot_o = quo_d;
  end

  // Operand load on start, then iterate until the bit counter runs out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= num_i;
      den_q <= den_i;
      cnt_q <= C_W'(N_W);
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - C_W'(1);
      run_q <= (cnt_q != C_W'(1));
    end
  end

endmodule

// File: rtl/wait_time_calc.sv
// Estimated customer wait time: SVC_TIME*(Pcount+Tcount-1)/Tcount (floor),
// zero when either count is zero, saturated to W_W bits with an overflow flag.
// Valid/ready handshake on both sides; one request in flight at a time.
module wait_time_calc
  import sbqm_pkg::*;
#(
  parameter int unsigned P_W      = P_W_DEF,
  parameter int unsigned T_W      = T_W_DEF,
  parameter int unsigned SVC_TIME = SVC_TIME_DEF,
  parameter int unsigned W_W      = W_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P_W-1:0] Pcount,
  input  logic [T_W-1:0] Tcount,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_W-1:0] Wtime,
  output logic           overflow,
  output logic           busy
);

  localparam int unsigned NUM_W = num_width(P_W, T_W, SVC_TIME);
  localparam int unsigned WMAX  = (32'd1 << W_W) - 32'd1;

  state_e         state_q, state_d;
  logic [W_W-1:0] wtime_q, wtime_d;
  logic           ovf_q, ovf_d;
  logic           zero_req;
  logic           div_start;
  logic           div_done;
  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] div_quot;

  // Numerator build and zero-count bypass detection from the live inputs.
  always_comb begin
    zero_req = (Pcount == '0) || (Tcount == '0);
    num      = NUM_W'(SVC_TIME * (32'(Pcount) + 32'(Tcount) - 32'd1));
  end

  seq_divider #(
    .N_W (NUM_W),
    .D_W (T_W)
  ) u_div (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (div_start),
    .num_i   (num),
    .den_i   (Tcount),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  // Next-state, divider start and result capture with saturation.
  always_comb begin
    state_d   = state_q;
    wtime_d   = wtime_q;
    ovf_d     = ovf_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (zero_req) begin
            wtime_d = '0;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            div_start = 1'b1;
            state_d   = DIV;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          if (32'(div_quot) > WMAX) begin
            wtime_d = '1;
            ovf_d   = 1'b1;
          end else begin
            wtime_d = W_W'(div_quot);
            ovf_d   = 1'b0;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wtime_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wtime_q <= wtime_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Wtime     = wtime_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_wait_time_calc.sv
// Randomized self-checking bench for wait_time_calc against an arithmetic
// reference model; instance 0 uses defaults, instance 1 a saturating setup.
module tb_wait_time_calc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid_a  [2];
  logic       out_ready_a [2];
  logic       in_ready_a  [2];
  logic       out_valid_a [2];
  logic       busy_a      [2];
  logic       ovf_a       [2];
  logic [2:0] pc_a        [2];
  logic [1:0] tc_a        [2];
  logic [4:0] wt0;
  logic [3:0] wt1;

  int checks = 0;
  int errors = 0;

  wait_time_calc #(.P_W(3), .T_W(2), .SVC_TIME(3), .W_W(5)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a[0]),
    .in_ready  (in_ready_a[0]),
    .Pcount    (pc_a[0]),
    .Tcount    (tc_a[0]),
    .out_valid (out_valid_a[0]),
    .out_ready (out_ready_a[0]),
    .Wtime     (wt0),
    .overflow  (ovf_a[0]),
    .busy      (busy_a[0])
  );

  wait_time_calc #(.P_W(3), .T_W(2), .SVC_TIME(5), .W_W(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_a[1]),
    .in_ready  (in_ready_a[1]),
    .Pcount    (pc_a[1]),
    .Tcount    (tc_a[1]),
    .out_valid (out_valid_a[1]),
    .out_ready (out_ready_a[1]),
    .Wtime     (wt1),
    .overflow  (ovf_a[1]),
    .busy      (busy_a[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait time straight from the formula, with saturation.
  function automatic int model(input int p, input int t, input int svc,
                               input int ww, output int ov);
    int q;
    int lim;
    ov  = 0;
    lim = (1 << ww) - 1;
    if (p == 0 || t == 0) return 0;
    q = (svc * (p + t - 1)) / t;
    if (q > lim) begin
      ov = 1;
      return lim;
    end
    return q;
  endfunction

  function automatic int get_wt(input int sel);
    return (sel != 0) ? int'(wt1) : int'(wt0);
  endfunction

  task automatic do_req(input int sel, input int p, input int t, input int hold);
    int    exp_wt, exp_ov, exp_lat, n;
    string s;
    exp_wt  = model(p, t, (sel != 0) ? 5 : 3, (sel != 0) ? 4 : 5, exp_ov);
    exp_lat = (p == 0 || t == 0) ? 1 : ((sel != 0) ? 7 : 6);
    s = $sformatf("d%0d_t%0dp%0d", sel, t, p);
    @(negedge clk);
    chk({s, "_idle_rdy"}, int'(in_ready_a[sel]), 1);
    pc_a[sel]        = 3'(p);
    tc_a[sel]        = 2'(t);
    in_valid_a[sel]  = 1'b1;
    out_ready_a[sel] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pc_a[sel] = 3'($urandom);
      tc_a[sel] = 2'($urandom);
      if (!out_valid_a[sel]) begin
        chk({s, "_busy_rdy"}, int'(in_ready_a[sel]), 0);
        chk({s, "_busy"}, int'(busy_a[sel]), 1);
      end
    end while (!out_valid_a[sel] && n < 20);
    chk({s, "_lat"}, n, exp_lat);
    chk({s, "_wtime"}, get_wt(sel), exp_wt);
    chk({s, "_ovf"}, int'(ovf_a[sel]), exp_ov);
    chk({s, "_done_rdy"}, int'(in_ready_a[sel]), 0);
    repeat (hold) begin
      @(negedge clk);
      chk({s, "_hold_vld"}, int'(out_valid_a[sel]), 1);
      chk({s, "_hold_wt"}, get_wt(sel), exp_wt);
      chk({s, "_hold_ovf"}, int'(ovf_a[sel]), exp_ov);
      chk({s, "_hold_rdy"}, int'(in_ready_a[sel]), 0);
      chk({s, "_hold_busy"}, int'(busy_a[sel]), 1);
    end
    in_valid_a[sel]  = 1'b0;
    out_ready_a[sel] = 1'b1;
    @(negedge clk);
    out_ready_a[sel] = 1'b0;
    chk({s, "_rel_vld"}, int'(out_valid_a[sel]), 0);
    chk({s, "_rel_rdy"}, int'(in_ready_a[sel]), 1);
    chk({s, "_keep_wt"}, get_wt(sel), exp_wt);
    chk({s, "_keep_ovf"}, int'(ovf_a[sel]), exp_ov);
  endtask

  initial begin
    bit any_vld;
    for (int i = 0; i < 2; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
      pc_a[i]        = '0;
      tc_a[i]        = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy",  int'(in_ready_a[0]), 1);
    chk("rst_vld",  int'(out_valid_a[0]), 0);
    chk("rst_wt",   get_wt(0), 0);
    chk("rst_ovf",  int'(ovf_a[0]), 0);
    chk("rst_busy", int'(busy_a[0]), 0);
    chk("rst_wt1",  get_wt(1), 0);
    rst = 1'b0;

    // Full table sweep at defaults, consumer always ready.
    for (int t = 0; t < 4; t++)
      for (int p = 0; p < 8; p++)
        do_req(0, p, t, 0);

    // Backpressure in DONE with in_valid held high meanwhile.
    do_req(0, 3, 3, 4);

    repeat (30) do_req(0, int'($urandom_range(7)), int'($urandom_range(3)),
                       int'($urandom_range(4)));

    // Saturating instance: 35 -> 15 with overflow, exact-max boundary, etc.
    do_req(1, 7, 1, 4);
    do_req(1, 7, 3, 0);
    do_req(1, 6, 1, 1);
    do_req(1, 3, 2, 0);
    do_req(1, 0, 2, 0);
    repeat (10) do_req(1, int'($urandom_range(7)), int'($urandom_range(3)),
                       int'($urandom_range(2)));

    // Leave a nonzero result behind, then reset in the middle of a division.
    do_req(0, 7, 1, 0);
    @(negedge clk);
    pc_a[0] = 3'd7;
    tc_a[0] = 2'd2;
    in_valid_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    chk("mid_busy", int'(busy_a[0]), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld",  int'(out_valid_a[0]), 0);
    chk("mid_rst_rdy",  int'(in_ready_a[0]), 1);
    chk("mid_rst_busy", int'(busy_a[0]), 0);
    chk("mid_rst_wt",   get_wt(0), 0);
    chk("mid_rst_ovf",  int'(ovf_a[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    any_vld = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_vld |= out_valid_a[0];
    end
    chk("mid_no_vld", int'(any_vld), 0);
    do_req(0, 4, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
